// File: rtl/vga_sync_monitor.sv
// rtl/vga_sync_monitor.sv - VGA output-bus timing checker with lock, sticky errors, frame count and pixel capture
//
// Samples the VGA bus on CLOCK_50 and measures line/frame timing once per pixel
// tick (VGA_CLK rising, seen as data).
// Optional build macro: CHECK_ACTIVE_EN compiles in the H/V active-area checks
// (err_flags[5:4]); without it those bits read 0.
//
// Ports:
//   CLOCK_50      in   system clock (sole clock)
//   resetn        in   asynchronous active-low reset
//   VGA_CLK       in   pixel clock, sampled as data
//   VGA_HS/VGA_VS in   syncs, active low
//   VGA_BLANK_N   in   high during active video
//   VGA_R/G/B     in   8-bit colour
//   clear_err     in   one-cycle pulse, clears err_flags
//   cap_x/cap_y   in   active-area coordinate of the capture pixel
//   locked        out  timing verified for a full frame
//   err_flags     out  sticky: [0] H period [1] H sync [2] V period [3] V sync [4] H active [5] V active
//   frame_count   out  frames completed while locked (wraps)
//   cap_rgb       out  {R,G,B} of captured pixel
//   cap_valid     out  one-cycle pulse when cap_rgb updates
`timescale 1ns/1ps
module vga_sync_monitor #(
    parameter int H_TOTAL  = 800,
    parameter int H_SYNC   = 96,
    parameter int H_ACTIVE = 640,
    parameter int V_TOTAL  = 525,
    parameter int V_SYNC   = 2,
    parameter int V_ACTIVE = 480,
    parameter int TIMEOUT  = 255
) (
    input  logic        CLOCK_50,
    input  logic        resetn,
    input  logic        VGA_CLK,
    input  logic        VGA_HS,
    input  logic        VGA_VS,
    input  logic        VGA_BLANK_N,
    input  logic [7:0]  VGA_R,
    input  logic [7:0]  VGA_G,
    input  logic [7:0]  VGA_B,
    input  logic        clear_err,
    input  logic [9:0]  cap_x,
    input  logic [8:0]  cap_y,
    output logic        locked,
    output logic [5:0]  err_flags,
    output logic [15:0] frame_count,
    output logic [23:0] cap_rgb,
    output logic        cap_valid
);

    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_UNLOCKED = 2'd0;
    localparam logic [1:0] S_ACQUIRE  = 2'd1;
    localparam logic [1:0] S_LOCKED   = 2'd2;

    localparam logic [10:0] C_MAX = 11'h7FF;

    function automatic logic [10:0] sat_inc(input logic [10:0] v);
        return (v == C_MAX) ? v : v + 11'd1;
    endfunction

    logic          r_clk_prev;
    logic          r_hs_prev;
    logic          r_vs_prev;
    logic [10:0]   r_h_cnt;
    logic [10:0]   r_hs_low;
    logic [10:0]   r_h_act;
    logic [10:0]   r_lines;
    logic [10:0]   r_vs_lines;
    logic [10:0]   r_v_act;
    logic [TW-1:0] r_to;
    logic [1:0]    r_state;
    logic          r_fm;
    logic          r_cap_done;

    logic          w_tick;
    logic          w_hs_fall;
    logic          w_hs_rise;
    logic          w_vs_fall;
    logic          w_vs_rise;
    logic          w_h_act_nz;
    logic [11:0]   w_lines_meas;
    logic [10:0]   w_v_act_now;
    logic [10:0]   w_cap_xpos;
    logic          w_cap_hit;
    logic          w_to_hit;
    logic [5:0]    w_mis;
    logic          w_any_mis;
    logic [1:0]    w_state_nxt;
    logic          w_fm_nxt;
    logic [5:0]    w_err_set;
    logic          w_fc_inc;

    // VGA_CLK is only data here: a tick is its first high sample.
    assign w_tick    = VGA_CLK & ~r_clk_prev;
    assign w_hs_fall = w_tick &  r_hs_prev & ~VGA_HS;
    assign w_hs_rise = w_tick & ~r_hs_prev &  VGA_HS;
    assign w_vs_fall = w_tick &  r_vs_prev & ~VGA_VS;
    assign w_vs_rise = w_tick & ~r_vs_prev &  VGA_VS;

    assign w_h_act_nz = (r_h_act != 11'd0);

    // Line count for the closing frame includes the HS fall on this very tick.
    assign w_lines_meas = {1'b0, r_lines} + {11'd0, w_hs_fall};

    // Active-line count including the line that closes on this tick; a VS
    // fall starts a new frame at y=0.
    assign w_v_act_now = w_vs_fall ? 11'd0 :
                         (w_hs_fall && w_h_act_nz) ? sat_inc(r_v_act) : r_v_act;

    // x of the current pixel: an HS fall tick is the first tick of a new line.
    assign w_cap_xpos = w_hs_fall ? 11'd0 : r_h_act;

    assign w_to_hit = ~w_tick && (r_to == TW'(TIMEOUT - 1));

    always_comb begin
        w_mis    = 6'd0;
        w_mis[0] = w_hs_fall && (({1'b0, r_h_cnt} + 12'd1) != 12'(H_TOTAL));
        w_mis[1] = w_hs_rise && (r_hs_low != 11'(H_SYNC));
        w_mis[2] = w_vs_fall && (w_lines_meas != 12'(V_TOTAL));
        w_mis[3] = w_vs_rise && (r_vs_lines != 11'(V_SYNC));
`ifdef CHECK_ACTIVE_EN
        // Blanking-only lines carry no active video and are not checked.
        w_mis[4] = w_hs_fall && w_h_act_nz && (r_h_act != 11'(H_ACTIVE));
        w_mis[5] = w_vs_fall &&
                   (({1'b0, r_v_act} + {11'd0, w_hs_fall && w_h_act_nz}) != 12'(V_ACTIVE));
`else
        w_mis[5:4] = 2'b00;
`endif
    end

    assign w_any_mis = |w_mis;

    // Coordinates outside the active area can never be captured.
    assign w_cap_hit = w_tick && (r_state == S_LOCKED) && VGA_BLANK_N && !r_cap_done &&
                       (w_cap_xpos == {1'b0, cap_x}) && (w_v_act_now == {2'b00, cap_y}) &&
                       (w_cap_xpos < 11'(H_ACTIVE)) && (w_v_act_now < 11'(V_ACTIVE));

    always_comb begin
        w_state_nxt = r_state;
        w_fm_nxt    = r_fm;
        w_err_set   = 6'd0;
        w_fc_inc    = 1'b0;
        if (w_to_hit) begin
            w_state_nxt = S_UNLOCKED;
        end else if (w_tick) begin
            case (r_state)
                S_UNLOCKED: begin
                    if (w_vs_fall) begin
                        w_state_nxt = S_ACQUIRE;
                        w_fm_nxt    = 1'b0;
                    end
                end
                S_ACQUIRE: begin
                    if (w_vs_fall) begin
                        if (!r_fm && !w_any_mis) begin
                            w_state_nxt = S_LOCKED;
                        end else begin
                            w_fm_nxt = 1'b0;
                        end
                    end else if (w_any_mis) begin
                        w_fm_nxt = 1'b1;
                    end
                end
                S_LOCKED: begin
                    if (w_any_mis) begin
                        w_err_set   = w_mis;
                        w_state_nxt = S_UNLOCKED;
                    end else if (w_vs_fall) begin
                        w_fc_inc = 1'b1;
                    end
                end
                default: w_state_nxt = S_UNLOCKED;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_clk_prev  <= 1'b0;
            r_hs_prev   <= 1'b1;
            r_vs_prev   <= 1'b1;
            r_h_cnt     <= 11'd0;
            r_hs_low    <= 11'd0;
            r_h_act     <= 11'd0;
            r_lines     <= 11'd0;
            r_vs_lines  <= 11'd0;
            r_v_act     <= 11'd0;
            r_to        <= '0;
            r_state     <= S_UNLOCKED;
            r_fm        <= 1'b0;
            r_cap_done  <= 1'b0;
            locked      <= 1'b0;
            err_flags   <= 6'd0;
            frame_count <= 16'd0;
            cap_rgb     <= 24'd0;
            cap_valid   <= 1'b0;
        end else begin
            r_clk_prev <= VGA_CLK;

            if (w_tick) begin
                r_to <= '0;
            end else if (r_to != TW'(TIMEOUT)) begin
                r_to <= r_to + 1'b1;
            end

            if (w_tick) begin
                r_hs_prev  <= VGA_HS;
                r_vs_prev  <= VGA_VS;
                r_h_cnt    <= w_hs_fall ? 11'd0 : sat_inc(r_h_cnt);
                r_hs_low   <= w_hs_fall ? 11'd1 : (!VGA_HS ? sat_inc(r_hs_low) : r_hs_low);
                r_h_act    <= w_hs_fall ? {10'd0, VGA_BLANK_N} :
                              (VGA_BLANK_N ? sat_inc(r_h_act) : r_h_act);
                r_lines    <= w_vs_fall ? 11'd0 : (w_hs_fall ? sat_inc(r_lines) : r_lines);
                r_vs_lines <= w_vs_fall ? {10'd0, w_hs_fall} :
                              ((w_hs_fall && !VGA_VS) ? sat_inc(r_vs_lines) : r_vs_lines);
                r_v_act    <= w_v_act_now;
                r_cap_done <= w_cap_hit | (r_cap_done & ~w_vs_fall);
            end

            r_state <= w_state_nxt;
            r_fm    <= w_fm_nxt;
            locked  <= (w_state_nxt == S_LOCKED);

            // A new error in the clearing cycle survives the clear.
            if (clear_err) begin
                err_flags <= w_err_set;
            end else begin
                err_flags <= err_flags | w_err_set;
            end

            if (w_fc_inc) begin
                frame_count <= frame_count + 16'd1;
            end

            cap_valid <= w_cap_hit;
            if (w_cap_hit) begin
                cap_rgb <= {VGA_R, VGA_G, VGA_B};
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_monitor.sv
// tb/tb_vga_sync_monitor.sv - self-checking bench for vga_sync_monitor
`timescale 1ns/1ps
module tb_vga_sync_monitor;

    localparam int K_NONE = 0;
    localparam int K_HPER = 1;
    localparam int K_VSW  = 2;
    localparam int K_ACT  = 3;

    logic        CLOCK_50 = 1'b0;
    logic        resetn = 1'b1;
    logic        VGA_CLK = 1'b0;
    logic        VGA_HS = 1'b1;
    logic        VGA_VS = 1'b1;
    logic        VGA_BLANK_N = 1'b0;
    logic [7:0]  VGA_R = 8'd0;
    logic [7:0]  VGA_G = 8'd0;
    logic [7:0]  VGA_B = 8'd0;
    logic        clear_err = 1'b0;
    logic [9:0]  cap_x = 10'd1023;
    logic [8:0]  cap_y = 9'd0;
    logic        locked;
    logic [5:0]  err_flags;
    logic [15:0] frame_count;
    logic [23:0] cap_rgb;
    logic        cap_valid;

    int n_cmp = 0;
    int n_err = 0;

    logic [23:0] cap_q[$];
    logic [23:0] exp_rgb;
    int          cap_pulses = 0;
    logic        prev_cv = 1'b0;

    logic        first_locked;
    logic [5:0]  first_err;
    logic [15:0] first_fc;
    logic        post_locked;
    logic [5:0]  post_err;

    vga_sync_monitor #(
        .H_TOTAL(20), .H_SYNC(4), .H_ACTIVE(12),
        .V_TOTAL(10), .V_SYNC(2), .V_ACTIVE(6), .TIMEOUT(255)
    ) dut (
        .CLOCK_50(CLOCK_50), .resetn(resetn), .VGA_CLK(VGA_CLK),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .clear_err(clear_err), .cap_x(cap_x), .cap_y(cap_y),
        .locked(locked), .err_flags(err_flags), .frame_count(frame_count),
        .cap_rgb(cap_rgb), .cap_valid(cap_valid)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // Capture scoreboard: pops an expectation for every cap_valid pulse.
    always @(negedge CLOCK_50) begin
        if (cap_valid === 1'b1) begin
            cap_pulses++;
            n_cmp++;
            if (cap_q.size() == 0) begin
                n_err++;
                $display("FAIL cap_unexpected: cap_rgb=%h but no capture expected", cap_rgb);
            end else begin
                exp_rgb = cap_q.pop_front();
                if (cap_rgb !== exp_rgb) begin
                    n_err++;
                    $display("FAIL cap_rgb: got %h expected %h", cap_rgb, exp_rgb);
                end
            end
            if (prev_cv === 1'b1) begin
                n_cmp++;
                n_err++;
                $display("FAIL cap_pulse_width: cap_valid high 2 cycles, expected 1");
            end
        end
        prev_cv = cap_valid;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    task automatic pix(input logic hs, input logic vs, input logic bl, input logic [23:0] rgb);
        @(negedge CLOCK_50);
        VGA_CLK = 1'b1;
        VGA_HS = hs;
        VGA_VS = vs;
        VGA_BLANK_N = bl;
        {VGA_R, VGA_G, VGA_B} = rgb;
        @(negedge CLOCK_50);
        VGA_CLK = 1'b0;
    endtask

    // 20-tick lines: HS low 0..3, active 6..17. 10-line frames: VS low lines 0..1, active lines 3..8.
    task automatic drive_frame(input int kind, input int fline, input bit cap_on, input int stop_line);
        int nt;
        int vsn;
        int act_end;
        logic bl;
        logic [23:0] rgb;
        vsn = (kind == K_VSW) ? 3 : 2;
        for (int l = 0; l < stop_line; l++) begin
            nt = (kind == K_HPER && l == fline) ? 21 : 20;
            act_end = (kind == K_ACT && l == fline) ? 17 : 18;
            for (int t = 0; t < nt; t++) begin
                bl = (l >= 3 && l <= 8 && t >= 6 && t < act_end);
                rgb = 24'd0;
                if (cap_on && l == 6 && t == 11) begin
                    rgb = 24'hA55A3C;
                    cap_q.push_back(rgb);
                end
                pix(t >= 4, l >= vsn, bl, rgb);
                if (l == 0 && t == 0) begin
                    first_locked = locked;
                    first_err = err_flags;
                    first_fc = frame_count;
                end
                if (kind != K_NONE && l == fline + 1 && t == 0) begin
                    post_locked = locked;
                    post_err = err_flags;
                end
            end
        end
    endtask

    task automatic pulse_clear(input string name);
        @(negedge CLOCK_50);
        clear_err = 1'b1;
        @(negedge CLOCK_50);
        clear_err = 1'b0;
        n_cmp++;
        if (err_flags !== 6'd0) begin
            n_err++;
            $display("FAIL %s: err_flags=%b expected 000000", name, err_flags);
        end
    endtask

    task automatic test_reset;
        #5 resetn = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        n_cmp++;
        if ({locked, err_flags, frame_count, cap_rgb, cap_valid} !== 48'd0) begin
            n_err++;
            $display("FAIL reset_outputs: locked=%b err=%b fc=%0d rgb=%h cv=%b expected all 0",
                     locked, err_flags, frame_count, cap_rgb, cap_valid);
        end
        resetn = 1'b1;
        drive_frame(K_NONE, 0, 0, 10);
        n_cmp++;
        if (first_locked !== 1'b0) begin
            n_err++;
            $display("FAIL reset_f1_locked: locked=%b expected 0", first_locked);
        end
        drive_frame(K_NONE, 0, 0, 10);
        n_cmp++;
        if (first_locked !== 1'b1) begin
            n_err++;
            $display("FAIL reset_lock_2nd_vs: locked=%b expected 1", first_locked);
        end
        n_cmp++;
        if (first_err !== 6'd0) begin
            n_err++;
            $display("FAIL reset_err_clean: err=%b expected 000000", first_err);
        end
        drive_frame(K_NONE, 0, 0, 10);
        n_cmp++;
        if (first_fc !== 16'd1) begin
            n_err++;
            $display("FAIL reset_fc_3rd_vs: fc=%0d expected 1", first_fc);
        end
    endtask

    task automatic test_h_period;
        drive_frame(K_HPER, 4, 0, 10);
        n_cmp++;
        if (first_fc !== 16'd2) begin
            n_err++;
            $display("FAIL hper_fc: fc=%0d expected 2", first_fc);
        end
        n_cmp++;
        if (post_err !== 6'b000001) begin
            n_err++;
            $display("FAIL hper_err: err=%b expected 000001", post_err);
        end
        n_cmp++;
        if (post_locked !== 1'b0) begin
            n_err++;
            $display("FAIL hper_unlock: locked=%b expected 0", post_locked);
        end
        drive_frame(K_NONE, 0, 0, 10);
        n_cmp++;
        if (first_locked !== 1'b0) begin
            n_err++;
            $display("FAIL hper_acquire: locked=%b expected 0", first_locked);
        end
        drive_frame(K_NONE, 0, 0, 10);
        n_cmp++;
        if (first_locked !== 1'b1 || first_err !== 6'b000001) begin
            n_err++;
            $display("FAIL hper_relock: locked=%b err=%b expected 1 / 000001", first_locked, first_err);
        end
        pulse_clear("hper_clear");
    endtask

    task automatic test_vs_width;
        drive_frame(K_VSW, 2, 0, 10);
        n_cmp++;
        if (first_fc !== 16'd3) begin
            n_err++;
            $display("FAIL vsw_fc: fc=%0d expected 3", first_fc);
        end
        n_cmp++;
        if (post_err !== 6'b001000 || post_locked !== 1'b0) begin
            n_err++;
            $display("FAIL vsw_err: err=%b locked=%b expected 001000 / 0", post_err, post_locked);
        end
        drive_frame(K_NONE, 0, 0, 10);
        drive_frame(K_NONE, 0, 0, 10);
        n_cmp++;
        if (first_locked !== 1'b1 || first_fc !== 16'd3) begin
            n_err++;
            $display("FAIL vsw_hold: locked=%b fc=%0d expected 1 / 3", first_locked, first_fc);
        end
    endtask

    task automatic test_clock_loss;
        n_cmp++;
        if (locked !== 1'b1) begin
            n_err++;
            $display("FAIL clk_pre_locked: locked=%b expected 1", locked);
        end
        for (int k = 1; k <= 300; k++) begin
            @(negedge CLOCK_50);
            if (k == 254) begin
                n_cmp++;
                if (locked !== 1'b1) begin
                    n_err++;
                    $display("FAIL clk_early_drop: locked=%b after 254 idle cycles expected 1", locked);
                end
            end
            if (k == 255) begin
                n_cmp++;
                if (locked !== 1'b0) begin
                    n_err++;
                    $display("FAIL clk_timeout: locked=%b after 255 idle cycles expected 0", locked);
                end
            end
        end
        n_cmp++;
        if (err_flags !== 6'b001000 || frame_count !== 16'd3) begin
            n_err++;
            $display("FAIL clk_err_hold: err=%b fc=%0d expected 001000 / 3", err_flags, frame_count);
        end
        pulse_clear("clk_clear");
        drive_frame(K_NONE, 0, 0, 10);
        drive_frame(K_NONE, 0, 0, 10);
        n_cmp++;
        if (first_locked !== 1'b1 || first_fc !== 16'd3) begin
            n_err++;
            $display("FAIL clk_relock: locked=%b fc=%0d expected 1 / 3", first_locked, first_fc);
        end
    endtask

    task automatic test_capture;
        cap_x = 10'd5;
        cap_y = 9'd3;
        drive_frame(K_NONE, 0, 1, 10);
        drive_frame(K_NONE, 0, 1, 10);
        n_cmp++;
        if (cap_pulses !== 2 || cap_q.size() !== 0) begin
            n_err++;
            $display("FAIL cap_count: pulses=%0d pending=%0d expected 2 / 0", cap_pulses, cap_q.size());
        end
        n_cmp++;
        if (first_fc !== 16'd5) begin
            n_err++;
            $display("FAIL cap_fc: fc=%0d expected 5", first_fc);
        end
        cap_x = 10'd1023;
        cap_y = 9'd0;
    endtask

    task automatic test_active;
        drive_frame(K_ACT, 5, 0, 10);
`ifdef CHECK_ACTIVE_EN
        n_cmp++;
        if (post_err !== 6'b010000 || post_locked !== 1'b0) begin
            n_err++;
            $display("FAIL act_err: err=%b locked=%b expected 010000 / 0", post_err, post_locked);
        end
`else
        n_cmp++;
        if (post_err !== 6'b000000 || post_locked !== 1'b1) begin
            n_err++;
            $display("FAIL act_ignored: err=%b locked=%b expected 000000 / 1", post_err, post_locked);
        end
`endif
        drive_frame(K_NONE, 0, 0, 10);
        drive_frame(K_NONE, 0, 0, 10);
        n_cmp++;
        if (first_locked !== 1'b1) begin
            n_err++;
            $display("FAIL act_relock: locked=%b expected 1", first_locked);
        end
        pulse_clear("act_clear");
    endtask

    task automatic test_reset_midframe;
        drive_frame(K_NONE, 0, 0, 5);
        @(negedge CLOCK_50);
        resetn = 1'b0;
        @(negedge CLOCK_50);
        n_cmp++;
        if ({locked, err_flags, frame_count, cap_valid} !== 24'd0) begin
            n_err++;
            $display("FAIL midreset_outputs: locked=%b err=%b fc=%0d cv=%b expected all 0",
                     locked, err_flags, frame_count, cap_valid);
        end
        resetn = 1'b1;
        drive_frame(K_NONE, 0, 0, 10);
        n_cmp++;
        if (first_locked !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_acquire: locked=%b expected 0", first_locked);
        end
        drive_frame(K_NONE, 0, 0, 10);
        n_cmp++;
        if (first_locked !== 1'b1 || first_fc !== 16'd0) begin
            n_err++;
            $display("FAIL midreset_relock: locked=%b fc=%0d expected 1 / 0", first_locked, first_fc);
        end
    endtask

    initial begin
        test_reset();
        test_h_period();
        test_vs_width();
        test_clock_loss();
        test_capture();
        test_active();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
